// File: rtl/reservation_station.sv
// Tomasulo reservation station in front of the integer functional unit.
// Holds decoded ops until both operands are valid, snoops two CDB ports for
// pending operands, and dispatches the oldest ready op as a registered bundle.
//
// Ports:
//   clk, reset (async, active-high), flush (sync clear of all entries)
//   issue_valid/issue_ready       : decode handshake (ready = any free slot)
//   issue_ctrl/dest/rj/rk/vj/vk/qj/qk : op, dest tag, operand values or tags
//   cdb0, cdb1                    : {valid, tag, data} result broadcasts
//   disp_stall                    : FU cannot accept this cycle
//   disp_a/b/ctrl/tag/issued      : registered dispatch bundle to the FU
module reservation_station #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [1:0]                issue_ctrl,
  input  logic [TAG_W-1:0]          issue_dest,
  input  logic                      issue_rj,
  input  logic                      issue_rk,
  input  logic [DATA_W-1:0]         issue_vj,
  input  logic [DATA_W-1:0]         issue_vk,
  input  logic [TAG_W-1:0]          issue_qj,
  input  logic [TAG_W-1:0]          issue_qk,
  input  logic [TAG_W+DATA_W:0]     cdb0,
  input  logic [TAG_W+DATA_W:0]     cdb1,
  input  logic                      disp_stall,
  output logic [DATA_W-1:0]         disp_a,
  output logic [DATA_W-1:0]         disp_b,
  output logic [1:0]                disp_ctrl,
  output logic [TAG_W-1:0]          disp_tag,
  output logic                      disp_issued
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Entry state
  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] rj;
  logic [ENTRIES-1:0] rk;
  logic [1:0]         ctrl [ENTRIES];
  logic [TAG_W-1:0]   dest [ENTRIES];
  logic [DATA_W-1:0]  vj   [ENTRIES];
  logic [DATA_W-1:0]  vk   [ENTRIES];
  logic [TAG_W-1:0]   qj   [ENTRIES];
  logic [TAG_W-1:0]   qk   [ENTRIES];
  // older[i][j] = 1 when entry i was allocated before entry j; only
  // meaningful between busy entries.
  logic [ENTRIES-1:0] older [ENTRIES];

  // CDB fields
  logic              c0_v, c1_v;
  logic [TAG_W-1:0]  c0_tag, c1_tag;
  logic [DATA_W-1:0] c0_d, c1_d;

  assign c0_v   = cdb0[TAG_W+DATA_W];
  assign c0_tag = cdb0[TAG_W+DATA_W-1:DATA_W];
  assign c0_d   = cdb0[DATA_W-1:0];
  assign c1_v   = cdb1[TAG_W+DATA_W];
  assign c1_tag = cdb1[TAG_W+DATA_W-1:DATA_W];
  assign c1_d   = cdb1[DATA_W-1:0];

  // Allocation
  logic             alloc_en;
  logic [IDX_W-1:0] alloc_idx;

  assign issue_ready = ~&busy;
  assign alloc_en    = issue_valid & issue_ready & ~flush;

  always_comb begin
    alloc_idx = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!busy[i-1]) alloc_idx = IDX_W'(i - 1);
    end
  end

  // Issue-time bypass from the CDB (cdb0 has priority)
  logic              bj0, bj1, bk0, bk1;
  logic              new_rj, new_rk;
  logic [DATA_W-1:0] new_vj, new_vk;

  always_comb begin
    bj0    = c0_v && (c0_tag == issue_qj);
    bj1    = c1_v && (c1_tag == issue_qj);
    bk0    = c0_v && (c0_tag == issue_qk);
    bk1    = c1_v && (c1_tag == issue_qk);
    new_rj = issue_rj | bj0 | bj1;
    new_rk = issue_rk | bk0 | bk1;
    new_vj = issue_rj ? issue_vj : (bj0 ? c0_d : c1_d);
    new_vk = issue_rk ? issue_vk : (bk0 ? c0_d : c1_d);
  end

  // Snoop hits per entry
  logic [ENTRIES-1:0] hj0, hj1, hk0, hk1;

  always_comb begin
    hj0 = '0;
    hj1 = '0;
    hk0 = '0;
    hk1 = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      hj0[i] = c0_v && (c0_tag == qj[i]);
      hj1[i] = c1_v && (c1_tag == qj[i]);
      hk0[i] = c0_v && (c0_tag == qk[i]);
      hk1[i] = c1_v && (c1_tag == qk[i]);
    end
  end

  // Oldest-eligible selection: an eligible entry is chosen when no other
  // eligible entry is older than it. Allocation order is strict, so at most
  // one entry qualifies.
  logic [ENTRIES-1:0] eligible;
  logic [ENTRIES-1:0] sel_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_en;

  always_comb begin
    logic blocked;
    blocked  = 1'b0;
    eligible = busy & rj & rk;
    sel_oh   = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        if (j != i && eligible[j] && older[j][i]) blocked = 1'b1;
      end
      sel_oh[i] = eligible[i] & ~blocked;
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    disp_en = (|eligible) & ~disp_stall & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      rj          <= '0;
      rk          <= '0;
      disp_a      <= '0;
      disp_b      <= '0;
      disp_ctrl   <= '0;
      disp_tag    <= '0;
      disp_issued <= 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctrl[i]  <= '0;
        dest[i]  <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        older[i] <= '0;
      end
    end else if (flush) begin
      busy        <= '0;
      disp_issued <= 1'b0;
    end else begin
      disp_issued <= disp_en;
      if (disp_en) begin
        disp_a          <= vj[sel_idx];
        disp_b          <= vk[sel_idx];
        disp_ctrl       <= ctrl[sel_idx];
        disp_tag        <= dest[sel_idx];
        busy[sel_idx]   <= 1'b0;
      end

      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (busy[i] && !rj[i]) begin
          if (hj0[i]) begin
            rj[i] <= 1'b1;
            vj[i] <= c0_d;
          end else if (hj1[i]) begin
            rj[i] <= 1'b1;
            vj[i] <= c1_d;
          end
        end
        if (busy[i] && !rk[i]) begin
          if (hk0[i]) begin
            rk[i] <= 1'b1;
            vk[i] <= c0_d;
          end else if (hk1[i]) begin
            rk[i] <= 1'b1;
            vk[i] <= c1_d;
          end
        end
      end

      // The allocated slot is non-busy, so it never collides with the
      // dispatch or snoop updates above.
      if (alloc_en) begin
        busy[alloc_idx]  <= 1'b1;
        ctrl[alloc_idx]  <= issue_ctrl;
        dest[alloc_idx]  <= issue_dest;
        rj[alloc_idx]    <= new_rj;
        rk[alloc_idx]    <= new_rk;
        vj[alloc_idx]    <= new_vj;
        vk[alloc_idx]    <= new_vk;
        qj[alloc_idx]    <= issue_qj;
        qk[alloc_idx]    <= issue_qk;
        older[alloc_idx] <= '0;
        for (int unsigned j = 0; j < ENTRIES; j++) begin
          if (IDX_W'(j) != alloc_idx) older[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule
